// File: rtl/imem_access_ctrl_if.sv
// Shared-port bundle between the instruction-memory access controller and its
// environment (core fetch path, program loader, single-port instruction memory).
//   fetch_*  : core fetch request / response
//   ld_*     : loader word handshake (valid/ready) plus sticky status
//   mem_*    : single-port memory strobe, write data and registered read data
// Modports: slave = the controller, master = the surrounding environment.
interface imem_access_ctrl_if #(
  parameter int unsigned AW = 6
);
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_valid;
  logic [31:0]   fetch_instr;
  logic          fetch_fault;
  logic          stall;

  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          boot_done;
  logic          ld_err;
  logic [AW:0]   words_loaded;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ld_last, mem_rdata,
    output fetch_valid, fetch_instr, fetch_fault, stall, ld_ready, boot_done,
           ld_err, words_loaded, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ld_last, mem_rdata,
    input  fetch_valid, fetch_instr, fetch_fault, stall, ld_ready, boot_done,
           ld_err, words_loaded, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_access_ctrl.sv
// Arbitration/sequencing controller in front of a DEPTH-word instruction memory.
// Holds the core stalled until the first image is loaded (BOOT), then serves
// fetches with 1-cycle latency (RUN); a loader request moves the port to the
// loader (LOAD) until its last word. Bad addresses are flagged, never accessed.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : imem_access_ctrl_if.slave (fetch, loader and memory signals)
module imem_access_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input logic               clk,
  input logic               reset,
  imem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic        boot_done_q, boot_done_d;
  logic        ld_err_q, ld_err_d;
  logic [AW:0] words_loaded_q, words_loaded_d;

  function automatic logic addr_good(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < 30'(DEPTH));
  endfunction

  logic fetch_good, ld_good;
  assign fetch_good = addr_good(bus.fetch_addr);
  assign ld_good    = addr_good(bus.ld_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= BOOT;
      fetch_valid_q  <= 1'b0;
      fetch_fault_q  <= 1'b0;
      boot_done_q    <= 1'b0;
      ld_err_q       <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      fetch_valid_q  <= fetch_valid_d;
      fetch_fault_q  <= fetch_fault_d;
      boot_done_q    <= boot_done_d;
      ld_err_q       <= ld_err_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_valid_d  = 1'b0;
    fetch_fault_d  = 1'b0;
    boot_done_d    = boot_done_q;
    ld_err_d       = ld_err_q;
    words_loaded_d = words_loaded_q;
    bus.ld_ready   = 1'b0;
    bus.stall      = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;

    unique case (state_q)
      RUN: begin
        if (bus.ld_valid) begin
          // Loader wins the port; the word itself is written next cycle in LOAD.
          bus.stall = bus.fetch_req;
          state_d   = LOAD;
        end else if (bus.fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_fault_d = !fetch_good;
          if (fetch_good) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.fetch_addr[AW+1:2];
          end
        end
      end
      default: begin // BOOT and LOAD behave identically apart from boot_done
        bus.ld_ready = 1'b1;
        bus.stall    = bus.fetch_req;
        if (bus.ld_valid) begin
          if (ld_good) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.ld_addr[AW+1:2];
            bus.mem_wdata = bus.ld_data;
            if (words_loaded_q != (AW+1)'(DEPTH))
              words_loaded_d = words_loaded_q + 1'b1;
          end else begin
            ld_err_d = 1'b1;
          end
          if (bus.ld_last) begin
            state_d = RUN;
            if (state_q == BOOT) boot_done_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Read data arrives from the memory's output register in the response cycle.
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.fetch_fault  = fetch_fault_q;
  assign bus.fetch_instr  = fetch_valid_q ? (fetch_fault_q ? NOP : bus.mem_rdata) : '0;
  assign bus.boot_done    = boot_done_q;
  assign bus.ld_err       = ld_err_q;
  assign bus.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
module tb_imem_access_ctrl;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] W0  = 32'h00500093;
  localparam logic [31:0] W1  = 32'h00A00113;
  localparam logic [31:0] W2  = 32'h002081B3;
  localparam logic [31:0] W3  = 32'h00308233;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  imem_access_ctrl_if #(.AW(6)) bus ();

  imem_access_ctrl #(.DEPTH(64), .AW(6), .NOP(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single-port memory with registered read data.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_fv"},   32'(bus.fetch_valid),  0);
    chk({tag, "_ff"},   32'(bus.fetch_fault),  0);
    chk({tag, "_fi"},   bus.fetch_instr,       0);
    chk({tag, "_boot"}, 32'(bus.boot_done),    0);
    chk({tag, "_lerr"}, 32'(bus.ld_err),       0);
    chk({tag, "_wl"},   32'(bus.words_loaded), 0);
  endtask

  logic [31:0] img [4];

  initial begin
    img[0] = W0; img[1] = W1; img[2] = W2; img[3] = W3;
    bus.mem_rdata = '0;
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_regs_zero("rst");
    reset = 1'b1;

    // Boot load of 4 words with the core already requesting.
    bus.fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'(4 * i);
      bus.ld_data  = img[i];
      bus.ld_last  = (i == 3);
      #1;
      chk("boot_stall", 32'(bus.stall), 1);
      chk("boot_rdy",   32'(bus.ld_ready), 1);
      chk("boot_en",    32'(bus.mem_en), 1);
      chk("boot_we",    32'(bus.mem_we), 1);
      chk("boot_addr",  32'(bus.mem_addr), 32'(i));
      chk("boot_wdata", bus.mem_wdata, img[i]);
      tick();
      chk("boot_fv", 32'(bus.fetch_valid), 0);
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    chk("boot_done", 32'(bus.boot_done), 1);
    chk("boot_wl",   32'(bus.words_loaded), 4);

    // Back-to-back fetches.
    for (int k = 0; k < 3; k++) begin
      bus.fetch_addr = 32'(4 * k);
      #1;
      chk("run_stall", 32'(bus.stall), 0);
      chk("run_rdy",   32'(bus.ld_ready), 0);
      chk("run_en",    32'(bus.mem_en), 1);
      chk("run_we",    32'(bus.mem_we), 0);
      chk("run_addr",  32'(bus.mem_addr), 32'(k));
      tick();
      chk("run_fv",    32'(bus.fetch_valid), 1);
      chk("run_ff",    32'(bus.fetch_fault), 0);
      chk("run_instr", bus.fetch_instr, img[k]);
    end
    bus.fetch_req = 1'b0;
    tick();
    chk("run_idle_fv", 32'(bus.fetch_valid), 0);

    // Faulting fetches: misaligned, then one word past the end.
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 32'h102;
    #1;
    chk("mis_en",    32'(bus.mem_en), 0);
    chk("mis_stall", 32'(bus.stall), 0);
    tick();
    chk("mis_fv",    32'(bus.fetch_valid), 1);
    chk("mis_ff",    32'(bus.fetch_fault), 1);
    chk("mis_instr", bus.fetch_instr, NOP);
    bus.fetch_addr = 32'h100;
    #1;
    chk("oor_en", 32'(bus.mem_en), 0);
    tick();
    chk("oor_fv",    32'(bus.fetch_valid), 1);
    chk("oor_ff",    32'(bus.fetch_fault), 1);
    chk("oor_instr", bus.fetch_instr, NOP);
    bus.fetch_req = 1'b0;
    tick();
    chk("oor_idle_fv", 32'(bus.fetch_valid), 0);

    // Fetch and loader collide: loader wins, held fetch later sees new data.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h4;
    bus.ld_valid   = 1'b1;
    bus.ld_addr    = 32'h4;
    bus.ld_data    = 32'hDEADBEEF;
    bus.ld_last    = 1'b1;
    #1;
    chk("col_stall", 32'(bus.stall), 1);
    chk("col_en",    32'(bus.mem_en), 0);
    chk("col_rdy",   32'(bus.ld_ready), 0);
    tick();
    chk("col_fv0", 32'(bus.fetch_valid), 0);
    #1;
    chk("ld_stall", 32'(bus.stall), 1);
    chk("ld_rdy",   32'(bus.ld_ready), 1);
    chk("ld_we",    32'(bus.mem_we), 1);
    chk("ld_addr",  32'(bus.mem_addr), 1);
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    chk("ld_wl", 32'(bus.words_loaded), 5);
    #1;
    chk("held_stall", 32'(bus.stall), 0);
    chk("held_addr",  32'(bus.mem_addr), 1);
    tick();
    chk("held_fv",    32'(bus.fetch_valid), 1);
    chk("held_instr", bus.fetch_instr, 32'hDEADBEEF);

    // Fetch accepted, then loader arrives: the response is still delivered.
    bus.fetch_addr = 32'h8;
    tick();
    bus.fetch_req = 1'b0;
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = 32'h200;
    bus.ld_data   = 32'h12345678;
    bus.ld_last   = 1'b1;
    chk("resp_fv",    32'(bus.fetch_valid), 1);
    chk("resp_instr", bus.fetch_instr, W2);
    tick();
    #1;
    chk("bad_en",  32'(bus.mem_en), 0);
    chk("bad_rdy", 32'(bus.ld_ready), 1);
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    chk("bad_err", 32'(bus.ld_err), 1);
    chk("bad_wl",  32'(bus.words_loaded), 5);
    tick();
    chk("bad_err_sticky", 32'(bus.ld_err), 1);

    // Reset mid-load after 2 of 4 words.
    reset = 1'b0;
    #1;
    chk_regs_zero("rst2");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'(4 * i);
      bus.ld_data  = img[i];
      tick();
    end
    chk("ml_wl", 32'(bus.words_loaded), 2);
    bus.ld_addr = 32'h8;
    bus.ld_data = img[2];
    #2;
    reset = 1'b0;
    #1;
    chk_regs_zero("ml");
    idle_inputs();
    tick();
    reset = 1'b1;

    // Back to RUN with a one-word image, then reset with a fetch in flight.
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h0;
    bus.ld_data  = W0;
    bus.ld_last  = 1'b1;
    tick();
    idle_inputs();
    chk("mf_boot", 32'(bus.boot_done), 1);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0;
    #1;
    chk("mf_en", 32'(bus.mem_en), 1);
    reset = 1'b0;
    #1;
    bus.fetch_req = 1'b0;
    tick();
    chk_regs_zero("mf");
    tick();
    chk("mf_no_fv", 32'(bus.fetch_valid), 0);
    reset = 1'b1;
    bus.fetch_req = 1'b1;
    #1;
    chk("mf_boot_rdy",   32'(bus.ld_ready), 1);
    chk("mf_boot_stall", 32'(bus.stall), 1);
    tick();
    chk("mf_boot_fv", 32'(bus.fetch_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
